// File: rtl/mem_dcache.sv
// Direct-mapped, one-word-per-line, write-through, read-allocate data cache driving a Wishbone master.
// Optional invalidate-all flush sequencer is compiled in with DCACHE_FLUSH_EN.
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif
`ifndef RW
`define RW 16
`endif

module mem_dcache #(
    parameter int unsigned LINE_BITS = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [`WB_ADDR_W-1:0] mem_addr,
    input  logic [`RW-1:0]        mem_o_data,
    input  logic [1:0]            mem_sel,
    input  logic                  mem_cache_enable,
    output logic                  mem_ack,
    output logic [`RW-1:0]        mem_i_data,
    output logic                  mem_exception,
    input  logic                  mem_flush,
    output logic                  flush_busy,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [`WB_ADDR_W-1:0] wb_adr,
    output logic [`RW-1:0]        wb_o_dat,
    output logic [1:0]            wb_sel,
    input  logic [`RW-1:0]        wb_i_dat,
    input  logic                  wb_ack,
    input  logic                  wb_err
);

    localparam int unsigned AW = `WB_ADDR_W;
    localparam int unsigned DW = `RW;
    localparam int unsigned TW = AW - LINE_BITS;
    localparam int unsigned NL = 1 << LINE_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_BUS,
        S_RESP
`ifdef DCACHE_FLUSH_EN
        , S_FLUSH
`endif
    } state_t;

    state_t state_q, state_d;

    logic          we_q, ce_q, hit_q, err_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdat_q, rdat_q;
    logic [1:0]    sel_q;

    logic [NL-1:0] valid_q;
    logic [TW-1:0] tag_q  [NL];
    logic [DW-1:0] line_q [NL];

    logic [LINE_BITS-1:0] idx;
    logic [TW-1:0]        tag;
    logic                 hit, rd_hit, bus_done;
    logic                 take_req, latch_now;

    assign idx      = addr_q[LINE_BITS-1:0];
    assign tag      = addr_q[AW-1:LINE_BITS];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign rd_hit   = !we_q && ce_q && hit;
    assign bus_done = wb_ack || wb_err;

    function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] cur,
                                                  input logic [DW-1:0] upd,
                                                  input logic [1:0]    sel);
        logic [DW-1:0] r;
        r = cur;
        for (int b = 0; b < 2; b++) begin
            if (sel[b]) r[b*8 +: 8] = upd[b*8 +: 8];
        end
        return r;
    endfunction

`ifdef DCACHE_FLUSH_EN
    logic                 flush_pend_q, req_pend_q, take_flush;
    logic [LINE_BITS-1:0] fcnt_q;

    // A request parked during a flush takes priority over any pending flush.
    always_comb begin
        take_req   = req_pend_q || mem_req;
        take_flush = !take_req && (flush_pend_q || mem_flush);
        latch_now  = mem_req && !req_pend_q && (state_q == S_IDLE || state_q == S_FLUSH);
    end
`else
    logic unused_flush;
    assign unused_flush = mem_flush;

    always_comb begin
        take_req  = mem_req;
        latch_now = mem_req && (state_q == S_IDLE);
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (take_req) state_d = S_LOOKUP;
`ifdef DCACHE_FLUSH_EN
                else if (take_flush) state_d = S_FLUSH;
`endif
            end
            S_LOOKUP: state_d = rd_hit ? S_IDLE : S_BUS;
            S_BUS:    if (bus_done) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
`ifdef DCACHE_FLUSH_EN
            S_FLUSH:  if (fcnt_q == LINE_BITS'(NL - 1)) state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // Hits answer combinationally from the array in LOOKUP; bus results come from registered data in RESP.
    always_comb begin
        mem_ack       = 1'b0;
        mem_exception = 1'b0;
        mem_i_data    = '0;
        flush_busy    = 1'b0;
        case (state_q)
            S_LOOKUP: begin
                if (rd_hit) begin
                    mem_ack    = 1'b1;
                    mem_i_data = line_q[idx];
                end
            end
            S_RESP: begin
                mem_ack       = !err_q;
                mem_exception = err_q;
                mem_i_data    = rdat_q;
            end
`ifdef DCACHE_FLUSH_EN
            S_FLUSH: flush_busy = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q  <= '0;
            we_q     <= 1'b0;
            ce_q     <= 1'b0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdat_q   <= '0;
            rdat_q   <= '0;
            sel_q    <= '0;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= '0;
            wb_o_dat <= '0;
            wb_sel   <= '0;
`ifdef DCACHE_FLUSH_EN
            flush_pend_q <= 1'b0;
            req_pend_q   <= 1'b0;
            fcnt_q       <= '0;
`endif
        end else begin
            if (latch_now) begin
                we_q   <= mem_we;
                addr_q <= mem_addr;
                wdat_q <= mem_o_data;
                sel_q  <= mem_sel;
                ce_q   <= mem_cache_enable;
            end
            case (state_q)
                S_LOOKUP: begin
                    hit_q <= hit;
                    if (!rd_hit) begin
                        wb_cyc   <= 1'b1;
                        wb_stb   <= 1'b1;
                        wb_we    <= we_q;
                        wb_adr   <= addr_q;
                        wb_o_dat <= wdat_q;
                        wb_sel   <= (!we_q && ce_q) ? 2'b11 : sel_q;
                    end
                end
                S_BUS: begin
                    if (bus_done) begin
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        err_q  <= wb_err;
                        rdat_q <= wb_err ? '0 : wb_i_dat;
                        if (!wb_err) begin
                            if (!we_q && ce_q) begin
                                valid_q[idx] <= 1'b1;
                                tag_q[idx]   <= tag;
                                line_q[idx]  <= wb_i_dat;
                            end else if (we_q && hit_q) begin
                                line_q[idx] <= merge_lanes(line_q[idx], wdat_q, sel_q);
                            end
                        end
                    end
                end
                default: ;
            endcase
`ifdef DCACHE_FLUSH_EN
            // Flush requests that cannot start now are remembered once.
            if (state_q == S_IDLE && take_flush) begin
                flush_pend_q <= 1'b0;
                fcnt_q       <= '0;
            end else if (mem_flush) begin
                flush_pend_q <= 1'b1;
            end
            if (state_q == S_FLUSH) begin
                valid_q[fcnt_q] <= 1'b0;
                fcnt_q          <= fcnt_q + LINE_BITS'(1);
            end
            if (state_q == S_FLUSH && latch_now)      req_pend_q <= 1'b1;
            else if (state_q == S_IDLE && req_pend_q) req_pend_q <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_mem_dcache.sv
// Self-checking bench for mem_dcache: directed vector table, reset/flush sequences, random traffic vs a cache model.
`timescale 1ns/1ps
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif
`ifndef RW
`define RW 16
`endif

module tb_mem_dcache;

    localparam int unsigned AW = `WB_ADDR_W;
    localparam int unsigned DW = `RW;
    localparam int unsigned LB = 6;
    localparam int unsigned NL = 1 << LB;
    localparam int unsigned TW = AW - LB;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          mem_req = 1'b0, mem_we = 1'b0, mem_cache_enable = 1'b0, mem_flush = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_o_data = '0;
    logic [1:0]    mem_sel = '0;
    logic          mem_ack, mem_exception, flush_busy;
    logic [DW-1:0] mem_i_data;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_o_dat;
    logic [1:0]    wb_sel;
    logic [DW-1:0] wb_i_dat = '0;
    logic          wb_ack = 1'b0, wb_err = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    mem_dcache #(.LINE_BITS(LB)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_o_data(mem_o_data),
        .mem_sel(mem_sel), .mem_cache_enable(mem_cache_enable),
        .mem_ack(mem_ack), .mem_i_data(mem_i_data), .mem_exception(mem_exception),
        .mem_flush(mem_flush), .flush_busy(flush_busy),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_o_dat(wb_o_dat), .wb_sel(wb_sel), .wb_i_dat(wb_i_dat),
        .wb_ack(wb_ack), .wb_err(wb_err)
    );

    // Backing memory seen through Wishbone, plus the expected cache contents.
    logic [DW-1:0] smem [logic [AW-1:0]];
    bit            m_v [NL];
    logic [TW-1:0] m_t [NL];
    logic [DW-1:0] m_d [NL];

    typedef struct {
        bit            bus;
        bit            stb_ok;
        logic [1:0]    bsel;
        logic          bwe;
        logic [AW-1:0] badr;
        logic [DW-1:0] bdat;
        bit            ack;
        bit            exc;
        logic [DW-1:0] data;
        int            lat;
        int            ackc;
        bit            pulse_ok;
    } obs_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0]    s;
        logic          ce;
        int            errm;
        int            wt;
        bit            e_bus;
        logic [1:0]    e_sel;
        bit            e_exc;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t tv [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] cur, input logic [DW-1:0] upd,
                                            input logic [1:0] s);
        logic [DW-1:0] r;
        r = cur;
        if (s[0]) r[7:0]  = upd[7:0];
        if (s[1]) r[15:8] = upd[15:8];
        return r;
    endfunction

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (smem.exists(a)) return smem[a];
        return DW'(a ^ AW'(24'h00A5A5));
    endfunction

    function automatic bit model_hit(input logic [AW-1:0] a);
        int idx;
        idx = int'(a % AW'(NL));
        return m_v[idx] && (m_t[idx] == TW'(a / AW'(NL)));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(NL); i++) m_v[i] = 1'b0;
    endtask

    task automatic model_commit(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [1:0] s, input logic ce, input bit exc, input bit hit);
        int idx;
        idx = int'(a % AW'(NL));
        if (!exc) begin
            if (!we && ce) begin
                m_v[idx] = 1'b1;
                m_t[idx] = TW'(a / AW'(NL));
                m_d[idx] = mem_rd(a);
            end else if (we && hit) begin
                m_d[idx] = merge(m_d[idx], d, s);
            end
        end
    endtask

    // Issue one request and act as a Wishbone slave until the request completes or times out.
    task automatic run_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [1:0] s, input logic ce, input int errm, input int wt,
                           output obs_t o);
        int  ncyc;
        bit  done;
        o.bus = 0; o.stb_ok = 0; o.bsel = '0; o.bwe = 0; o.badr = '0; o.bdat = '0;
        o.ack = 0; o.exc = 0; o.data = '0; o.lat = 0; o.ackc = 0; o.pulse_ok = 0;
        ncyc = 0;
        done = 0;
        @(negedge i_clk);
        mem_req = 1'b1; mem_we = we; mem_addr = a; mem_o_data = d; mem_sel = s; mem_cache_enable = ce;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge i_clk);
            mem_req = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
            if (mem_ack || mem_exception) begin
                o.ack = mem_ack; o.exc = mem_exception; o.data = mem_i_data; o.lat = c;
                done = 1;
            end else if (wb_cyc) begin
                if (!o.bus) begin
                    o.bus = 1; o.stb_ok = wb_stb; o.bsel = wb_sel; o.bwe = wb_we;
                    o.badr = wb_adr; o.bdat = wb_o_dat;
                end
                if (ncyc == wt) begin
                    o.ackc = c;
                    if (errm == 0) begin
                        wb_ack = 1'b1;
                        if (wb_we) smem[wb_adr] = merge(mem_rd(wb_adr), wb_o_dat, wb_sel);
                        else       wb_i_dat = mem_rd(wb_adr);
                    end else begin
                        wb_err   = 1'b1;
                        wb_ack   = (errm == 2);
                        wb_i_dat = 16'hDEAD;
                    end
                end
                ncyc++;
            end
        end
        @(negedge i_clk);
        o.pulse_ok = !mem_ack && !mem_exception && !wb_cyc;
    endtask

    task automatic check_obs(input string nm, input obs_t o, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input bit e_bus, input logic [1:0] e_sel,
                             input bit e_exc, input logic [DW-1:0] e_data);
        chk({nm, " bus"}, 32'(o.bus), 32'(e_bus));
        if (e_bus) begin
            chk({nm, " wb_sel"}, 32'(o.bsel), 32'(e_sel));
            chk({nm, " wb_we"}, 32'(o.bwe), 32'(we));
            chk({nm, " wb_adr"}, 32'(o.badr), 32'(a));
            chk({nm, " wb_stb"}, 32'(o.stb_ok), 32'd1);
            if (we) chk({nm, " wb_dat"}, 32'(o.bdat), 32'(d));
            chk({nm, " latency"}, 32'(o.lat), 32'(o.ackc + 1));
        end else begin
            chk({nm, " latency"}, 32'(o.lat), 32'd1);
        end
        chk({nm, " exception"}, 32'(o.exc), 32'(e_exc));
        chk({nm, " ack"}, 32'(o.ack), 32'(!e_exc));
        if (!we) chk({nm, " rdata"}, 32'(o.data), 32'(e_data));
        chk({nm, " one_pulse"}, 32'(o.pulse_ok), 32'd1);
    endtask

    task automatic model_txn(input string nm, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [1:0] s, input logic ce,
                             input int errm, input int wt);
        bit            hit, e_bus, e_exc;
        logic [1:0]    e_sel;
        logic [DW-1:0] e_data;
        obs_t          o;
        hit    = model_hit(a);
        e_bus  = we || !ce || !hit;
        e_sel  = (!we && ce) ? 2'b11 : s;
        e_exc  = e_bus && (errm != 0);
        e_data = !e_bus ? m_d[int'(a % AW'(NL))] : (e_exc ? '0 : mem_rd(a));
        run_txn(we, a, d, s, ce, errm, wt, o);
        check_obs(nm, o, we, a, d, e_bus, e_sel, e_exc, e_data);
        model_commit(we, a, d, s, ce, e_exc, hit);
    endtask

    initial begin
        obs_t o;
        bit   seen;
        int   cnt;

        smem[AW'(24'h10)] = 16'hBEEF;
        smem[AW'(24'h50)] = 16'h5050;
        smem[AW'(24'h20)] = 16'h2222;
        smem[AW'(24'h30)] = 16'h3030;
        smem[AW'(24'h15)] = 16'h1515;
        model_clear();

        // we, addr, wdata, sel, ce, errm(0 ack/1 err/2 both), wait, exp bus, exp sel, exp exc, exp rdata
        tv.push_back('{0, 24'h10, 16'h0000, 2'b01, 1, 0, 0, 1, 2'b11, 0, 16'hBEEF});
        tv.push_back('{0, 24'h10, 16'h0000, 2'b01, 1, 0, 0, 0, 2'b11, 0, 16'hBEEF});
        tv.push_back('{1, 24'h10, 16'h0012, 2'b01, 1, 0, 1, 1, 2'b01, 0, 16'h0000});
        tv.push_back('{0, 24'h10, 16'h0000, 2'b11, 1, 0, 0, 0, 2'b11, 0, 16'hBE12});
        tv.push_back('{0, 24'h50, 16'h0000, 2'b11, 1, 0, 2, 1, 2'b11, 0, 16'h5050});
        tv.push_back('{0, 24'h10, 16'h0000, 2'b11, 1, 0, 0, 1, 2'b11, 0, 16'hBE12});
        tv.push_back('{0, 24'h10, 16'h0000, 2'b11, 1, 0, 0, 0, 2'b11, 0, 16'hBE12});
        tv.push_back('{0, 24'h20, 16'h0000, 2'b10, 0, 0, 0, 1, 2'b10, 0, 16'h2222});
        tv.push_back('{0, 24'h20, 16'h0000, 2'b10, 0, 0, 1, 1, 2'b10, 0, 16'h2222});
        tv.push_back('{0, 24'h20, 16'h0000, 2'b01, 1, 0, 0, 1, 2'b11, 0, 16'h2222});
        tv.push_back('{0, 24'h20, 16'h0000, 2'b11, 1, 0, 0, 0, 2'b11, 0, 16'h2222});
        tv.push_back('{0, 24'h30, 16'h0000, 2'b11, 1, 1, 0, 1, 2'b11, 1, 16'h0000});
        tv.push_back('{0, 24'h30, 16'h0000, 2'b11, 1, 0, 0, 1, 2'b11, 0, 16'h3030});
        tv.push_back('{0, 24'h30, 16'h0000, 2'b11, 1, 0, 0, 0, 2'b11, 0, 16'h3030});
        tv.push_back('{1, 24'h70, 16'h1234, 2'b11, 1, 0, 0, 1, 2'b11, 0, 16'h0000});
        tv.push_back('{0, 24'h30, 16'h0000, 2'b11, 1, 0, 0, 0, 2'b11, 0, 16'h3030});
        tv.push_back('{0, 24'h70, 16'h0000, 2'b11, 1, 0, 0, 1, 2'b11, 0, 16'h1234});
        tv.push_back('{1, 24'h70, 16'hAB00, 2'b10, 0, 0, 0, 1, 2'b10, 0, 16'h0000});
        tv.push_back('{0, 24'h70, 16'h0000, 2'b11, 1, 0, 0, 0, 2'b11, 0, 16'hAB34});
        tv.push_back('{0, 24'h15, 16'h0000, 2'b11, 1, 2, 0, 1, 2'b11, 1, 16'h0000});
        tv.push_back('{0, 24'h15, 16'h0000, 2'b11, 1, 0, 0, 1, 2'b11, 0, 16'h1515});
        tv.push_back('{1, 24'h15, 16'h00FF, 2'b01, 1, 1, 0, 1, 2'b01, 1, 16'h0000});
        tv.push_back('{0, 24'h15, 16'h0000, 2'b11, 1, 0, 0, 0, 2'b11, 0, 16'h1515});

        // Reset values
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset mem_ack", 32'(mem_ack), 32'd0);
        chk("reset mem_exception", 32'(mem_exception), 32'd0);
        chk("reset mem_i_data", 32'(mem_i_data), 32'd0);
        chk("reset flush_busy", 32'(flush_busy), 32'd0);
        chk("reset wb_cyc_stb_we", 32'({wb_cyc, wb_stb, wb_we}), 32'd0);
        chk("reset wb_adr", 32'(wb_adr), 32'd0);
        chk("reset wb_o_dat", 32'(wb_o_dat), 32'd0);
        chk("reset wb_sel", 32'(wb_sel), 32'd0);
        i_rst = 1'b0;

        foreach (tv[i]) begin
            bit hit;
            hit = model_hit(tv[i].a);
            run_txn(tv[i].we, tv[i].a, tv[i].d, tv[i].s, tv[i].ce, tv[i].errm, tv[i].wt, o);
            check_obs($sformatf("vec%0d", i), o, tv[i].we, tv[i].a, tv[i].d, tv[i].e_bus,
                      tv[i].e_sel, tv[i].e_exc, tv[i].e_data);
            model_commit(tv[i].we, tv[i].a, tv[i].d, tv[i].s, tv[i].ce, tv[i].e_exc, hit);
        end

        // Reset in the middle of a bus read, with an ack landing on the reset edge
        @(negedge i_clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = AW'(24'h3F); mem_sel = 2'b11; mem_cache_enable = 1'b1;
        @(negedge i_clk);
        mem_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (wb_cyc) seen = 1;
            else @(negedge i_clk);
        end
        chk("rst_mid cyc_seen", 32'(seen), 32'd1);
        i_rst = 1'b1; wb_ack = 1'b1; wb_i_dat = 16'h7777;
        @(negedge i_clk);
        i_rst = 1'b0; wb_ack = 1'b0;
        chk("rst_mid cyc_stb", 32'({wb_cyc, wb_stb}), 32'd0);
        cnt = 0;
        repeat (5) begin
            @(negedge i_clk);
            if (mem_ack || mem_exception) cnt++;
        end
        chk("rst_mid no_ack", 32'(cnt), 32'd0);
        model_clear();
        model_txn("rst_mid reread", 0, AW'(24'h3F), '0, 2'b11, 1, 0, 0);
        model_txn("rst_clears_valid", 0, AW'(24'h10), '0, 2'b11, 1, 0, 0);

        // Flush with a same-cycle request: the request wins, then exactly 2^LINE_BITS busy cycles
        model_txn("flush fill", 0, AW'(24'h10), '0, 2'b11, 1, 0, 0);
        @(negedge i_clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = AW'(24'h10); mem_sel = 2'b11; mem_cache_enable = 1'b1;
        mem_flush = 1'b1;
        @(negedge i_clk);
        mem_req = 1'b0; mem_flush = 1'b0;
        chk("flush req_ack", 32'(mem_ack), 32'd1);
        chk("flush req_data", 32'(mem_i_data), 32'(m_d[16]));
        cnt = 0;
        repeat (90) begin
            @(negedge i_clk);
            if (flush_busy) cnt++;
        end
`ifdef DCACHE_FLUSH_EN
        chk("flush busy_cycles", 32'(cnt), 32'(NL));
        model_clear();
`else
        chk("flush busy_cycles", 32'(cnt), 32'd0);
`endif
        model_txn("after_flush read", 0, AW'(24'h10), '0, 2'b11, 1, 0, 0);

        // Random traffic over a few tags and indices to mix hits, aliasing and errors
        for (int i = 0; i < 300; i++) begin
            logic          we, ce;
            logic [AW-1:0] a;
            int            errm;
            we   = ($urandom_range(0, 2) == 0);
            ce   = ($urandom_range(0, 3) != 0);
            a    = AW'(($urandom_range(0, 3) << LB) | $urandom_range(0, 7));
            errm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            model_txn($sformatf("rnd%0d", i), we, a, DW'($urandom), 2'($urandom_range(1, 3)), ce,
                      errm, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
